// File: rtl/oled_frame_sequencer.sv
// SSD1306 128x64 sequencer: panel reset, init command list, then per-frame address window
// and 1024 pixel bytes fetched from the image controller and handed to the SPI byte transmitter.
module oled_frame_sequencer #(
  parameter int RST_CYCLES   = 27000,
  parameter int FRAME_PERIOD = 900000,
  parameter int FRAME_BYTES  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] byte_counter,
  input  logic [7:0] data_to_send,
  output logic [7:0] tx_data,
  output logic       tx_dc,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       panel_rst_n,
  output logic       frame_done,
  output logic       busy
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(FRAME_PERIOD + 1);

  typedef enum logic [2:0] {PANEL_LO, PANEL_HI, INIT, ADDR, FETCH, SEND, WAIT_FRAME} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] rst_cnt;
  logic [4:0]    cmd_idx;
  logic [2:0]    addr_idx;
  logic [TW-1:0] frame_tmr;
  logic          pending;
  logic [7:0]    pix_q;

  logic xfer, rst_done, tmr_exp, last_cmd, last_addr, last_pix;
  assign xfer      = tx_valid & tx_ready;
  assign rst_done  = (rst_cnt == RW'(RST_CYCLES - 1));
  assign tmr_exp   = (frame_tmr == TW'(FRAME_PERIOD - 1));
  assign last_cmd  = (cmd_idx == 5'd24);
  assign last_addr = (addr_idx == 3'd5);
  assign last_pix  = (byte_counter == 10'(FRAME_BYTES - 1));

  function automatic logic [7:0] init_byte(input logic [4:0] i);
    case (i)
      5'd0:  return 8'hAE;  5'd1:  return 8'hD5;  5'd2:  return 8'h80;  5'd3:  return 8'hA8;
      5'd4:  return 8'h3F;  5'd5:  return 8'hD3;  5'd6:  return 8'h00;  5'd7:  return 8'h40;
      5'd8:  return 8'h8D;  5'd9:  return 8'h14;  5'd10: return 8'h20;  5'd11: return 8'h00;
      5'd12: return 8'hA1;  5'd13: return 8'hC8;  5'd14: return 8'hDA;  5'd15: return 8'h12;
      5'd16: return 8'h81;  5'd17: return 8'hCF;  5'd18: return 8'hD9;  5'd19: return 8'hF1;
      5'd20: return 8'hDB;  5'd21: return 8'h40;  5'd22: return 8'hA4;  5'd23: return 8'hA6;
      5'd24: return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  // Column window 0..127, page window 0..7
  function automatic logic [7:0] addr_byte(input logic [2:0] i);
    case (i)
      3'd0: return 8'h21;  3'd1: return 8'h00;  3'd2: return 8'h7F;
      3'd3: return 8'h22;  3'd4: return 8'h00;  3'd5: return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= PANEL_LO;
    else        state <= state_nx;
  end

  // tx_data/tx_dc derive from state and indices that only move on a transfer, so they hold while stalled
  always_comb begin
    state_nx    = state;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    tx_dc       = 1'b0;
    panel_rst_n = 1'b1;
    busy        = 1'b1;
    unique case (state)
      PANEL_LO: begin
        panel_rst_n = 1'b0;
        if (rst_done) state_nx = PANEL_HI;
      end
      PANEL_HI: if (rst_done) state_nx = INIT;
      INIT: begin
        tx_valid = 1'b1;
        tx_data  = init_byte(cmd_idx);
        if (tx_ready && last_cmd) state_nx = ADDR;
      end
      ADDR: begin
        tx_valid = 1'b1;
        tx_data  = addr_byte(addr_idx);
        if (tx_ready && last_addr) state_nx = FETCH;
      end
      FETCH: state_nx = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = pix_q;
        tx_dc    = 1'b1;
        if (tx_ready) state_nx = last_pix ? WAIT_FRAME : FETCH;
      end
      WAIT_FRAME: begin
        busy = 1'b0;
        if (tmr_exp || pending) state_nx = ADDR;
      end
      default: state_nx = PANEL_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_cnt      <= '0;
      cmd_idx      <= '0;
      addr_idx     <= '0;
      byte_counter <= '0;
      pix_q        <= '0;
      frame_done   <= 1'b0;
      frame_tmr    <= '0;
      pending      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_tmr  <= tmr_exp ? '0 : frame_tmr + 1'b1;
      // Only one frame is ever queued no matter how many expiries land outside WAIT_FRAME
      if (state == WAIT_FRAME && state_nx == ADDR) pending <= 1'b0;
      else if (tmr_exp)                            pending <= 1'b1;
      if (state == PANEL_LO || state == PANEL_HI)
        rst_cnt <= rst_done ? '0 : rst_cnt + 1'b1;
      case (state)
        INIT: if (xfer && !last_cmd) cmd_idx <= cmd_idx + 1'b1;
        ADDR: if (xfer) begin
          if (last_addr) begin
            addr_idx     <= '0;
            byte_counter <= '0;
          end else addr_idx <= addr_idx + 1'b1;
        end
        FETCH: pix_q <= data_to_send;
        SEND: if (xfer) begin
          if (last_pix) begin
            byte_counter <= '0;
            frame_done   <= 1'b1;
          end else byte_counter <= byte_counter + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
